// File: rtl/lif_pkg.sv
// Shared constants and width helpers for the leaky integrate-and-fire layer.
package lif_pkg;

  localparam logic LIF_RESET_ZERO = 1'b0;
  localparam logic LIF_RESET_SUB  = 1'b1;

  // Wide enough that summing every weight of a row can never overflow.
  function automatic int lifCurrentWidth(input int weightW, input int numInputs);
    return weightW + $clog2(numInputs + 1);
  endfunction

endpackage

// File: rtl/lif_layer_if.sv
// Bus bundle for lif_layer: timestep strobe, spike vector, shared config, weights and read-outs.
interface lif_layer_if #(
  parameter int NUM_NEURONS = 4,
  parameter int NUM_INPUTS  = 8,
  parameter int WEIGHT_W    = 2,
  parameter int POT_W       = 5,
  parameter int DECAY_W     = 3,
  parameter int REFR_W      = 5
);

  localparam int SEL_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  logic                                     enable;
  logic [NUM_INPUTS-1:0]                    input_spikes;
  logic [NUM_NEURONS*NUM_INPUTS*WEIGHT_W-1:0] weights;
  logic [POT_W-1:0]                         threshold;
  logic [DECAY_W-1:0]                       decay;
  logic [REFR_W-1:0]                        refractory_period;
  logic                                     reset_mode;
  logic [SEL_W-1:0]                         dbg_sel;
  logic [POT_W-1:0]                         membrane_potential_out;
  logic [NUM_NEURONS-1:0]                   spike_out;

  modport master (
    output enable, input_spikes, weights, threshold, decay,
           refractory_period, reset_mode, dbg_sel,
    input  membrane_potential_out, spike_out
  );

  modport slave (
    input  enable, input_spikes, weights, threshold, decay,
           refractory_period, reset_mode, dbg_sel,
    output membrane_potential_out, spike_out
  );

endinterface

// File: rtl/lif_neuron_core.sv
// One leaky integrate-and-fire neuron: weighted input sum, leak, saturate, fire and refractory hold.
module lif_neuron_core
  import lif_pkg::*;
#(
  parameter int NUM_INPUTS = 8,
  parameter int WEIGHT_W   = 2,
  parameter int POT_W      = 5,
  parameter int DECAY_W    = 3,
  parameter int REFR_W     = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable_i,
  input  logic [NUM_INPUTS-1:0]          spikes_i,
  input  logic [NUM_INPUTS*WEIGHT_W-1:0] weights_i,
  input  logic [POT_W-1:0]               threshold_i,
  input  logic [DECAY_W-1:0]             decay_i,
  input  logic [REFR_W-1:0]              refrPeriod_i,
  input  logic                           resetMode_i,
  output logic [POT_W-1:0]               pot_o,
  output logic                           spike_o
);

  localparam int CUR_W  = lifCurrentWidth(WEIGHT_W, NUM_INPUTS);
  localparam int MAX_AB = (CUR_W > POT_W) ? CUR_W : POT_W;
  localparam int EXT_W  = ((MAX_AB > DECAY_W) ? MAX_AB : DECAY_W) + 1;

  localparam logic [EXT_W-1:0] POT_MAX = EXT_W'({POT_W{1'b1}});

  logic [CUR_W-1:0]  current;
  logic [EXT_W-1:0]  potExt;
  logic [EXT_W-1:0]  decayExt;
  logic [EXT_W-1:0]  leak;
  logic [EXT_W-1:0]  sum;
  logic [POT_W-1:0]  sat;
  logic              fire;

  logic [POT_W-1:0]  pot_q, pot_d;
  logic [REFR_W-1:0] refrCnt_q, refrCnt_d;
  logic              spike_q, spike_d;

  always_comb begin
    current = '0;
    for (int j = 0; j < NUM_INPUTS; j++) begin
      if (spikes_i[j]) begin
        current = current + CUR_W'(weights_i[j*WEIGHT_W +: WEIGHT_W]);
      end
    end
  end

  // Leak floors at zero and saturation happens before the threshold compare.
  always_comb begin
    potExt   = EXT_W'(pot_q);
    decayExt = EXT_W'(decay_i);
    leak     = (potExt >= decayExt) ? (potExt - decayExt) : '0;
    sum      = leak + EXT_W'(current);
    sat      = (sum > POT_MAX) ? {POT_W{1'b1}} : sum[POT_W-1:0];
    fire     = (sat >= threshold_i);
  end

  always_comb begin
    pot_d     = pot_q;
    refrCnt_d = refrCnt_q;
    spike_d   = 1'b0;
    if (enable_i) begin
      if (refrCnt_q != '0) begin
        refrCnt_d = refrCnt_q - 1'b1;
      end else if (fire) begin
        spike_d   = 1'b1;
        refrCnt_d = refrPeriod_i;
        pot_d     = '0;
        case (resetMode_i)
          LIF_RESET_ZERO: pot_d = '0;
          LIF_RESET_SUB:  pot_d = sat - threshold_i;
        endcase
      end else begin
        pot_d = sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pot_q     <= '0;
      refrCnt_q <= '0;
      spike_q   <= 1'b0;
    end else begin
      pot_q     <= pot_d;
      refrCnt_q <= refrCnt_d;
      spike_q   <= spike_d;
    end
  end

  assign pot_o   = pot_q;
  assign spike_o = spike_q;

endmodule

// File: rtl/lif_layer.sv
// Layer of parallel LIF neurons sharing one spike vector, plus a debug mux of stored potentials.
module lif_layer
  import lif_pkg::*;
#(
  parameter int NUM_NEURONS = 4,
  parameter int NUM_INPUTS  = 8,
  parameter int WEIGHT_W    = 2,
  parameter int POT_W       = 5,
  parameter int DECAY_W     = 3,
  parameter int REFR_W      = 5
) (
  input  logic       clk,
  input  logic       reset,
  lif_layer_if.slave bus
);

  localparam int SEL_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int ROW_W = NUM_INPUTS * WEIGHT_W;

  logic [POT_W-1:0]       potAll [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] spikeAll;
  logic [POT_W-1:0]       dbgPot;

  for (genvar n = 0; n < NUM_NEURONS; n++) begin : gNeuron
    lif_neuron_core #(
      .NUM_INPUTS (NUM_INPUTS),
      .WEIGHT_W   (WEIGHT_W),
      .POT_W      (POT_W),
      .DECAY_W    (DECAY_W),
      .REFR_W     (REFR_W)
    ) uCore (
      .clk          (clk),
      .rst_n        (reset),
      .enable_i     (bus.enable),
      .spikes_i     (bus.input_spikes),
      .weights_i    (bus.weights[n*ROW_W +: ROW_W]),
      .threshold_i  (bus.threshold),
      .decay_i      (bus.decay),
      .refrPeriod_i (bus.refractory_period),
      .resetMode_i  (bus.reset_mode),
      .pot_o        (potAll[n]),
      .spike_o      (spikeAll[n])
    );
  end

  // Indices with no neuron behind them fall through to zero.
  always_comb begin
    dbgPot = '0;
    for (int n = 0; n < NUM_NEURONS; n++) begin
      if (bus.dbg_sel == SEL_W'(n)) begin
        dbgPot = potAll[n];
      end
    end
  end

  assign bus.membrane_potential_out = dbgPot;
  assign bus.spike_out              = spikeAll;

endmodule

// File: doc/lif_layer.md
# lif_layer

Parametrised layer of leaky integrate-and-fire neurons. NUM_NEURONS neurons share one NUM_INPUTS-bit input spike vector. Each neuron has its own weight row, membrane potential and refractory counter. Threshold, decay, refractory period and reset mode are common to all neurons. The block replaces single-neuron instances in the network datapath and adds a selectable debug read-out of any neuron's potential.

## Interface
Parameters:
- NUM_NEURONS, 4, neurons in the layer (≥1)
- NUM_INPUTS, 8, input spike lines (≥1)
- WEIGHT_W, 2, unsigned weight width
- POT_W, 5, unsigned membrane potential / threshold width
- DECAY_W, 3, decay width
- REFR_W, 5, refractory counter width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- enable  in  1  timestep strobe; layer state advances only when 1
- input_spikes  in  NUM_INPUTS  spike vector for this timestep
- weights  in  NUM_NEURONS*NUM_INPUTS*WEIGHT_W  weight of input j for neuron n at bits [(n*NUM_INPUTS+j)*WEIGHT_W +: WEIGHT_W]
- threshold  in  POT_W  firing threshold
- decay  in  DECAY_W  leak subtracted per enabled timestep
- refractory_period  in  REFR_W  enabled timesteps ignored after a spike
- reset_mode  in  1  0 = reset potential to zero on spike, 1 = subtract threshold
- dbg_sel  in  clog2(NUM_NEURONS) (min 1)  neuron index for the debug read-out
- membrane_potential_out  out  POT_W  potential of neuron dbg_sel
- spike_out  out  NUM_NEURONS  registered spike per neuron

## Operation
- Per neuron n, the input current is I = Σ_j (input_spikes[j] ? w[n][j] : 0). It is computed at full width, WEIGHT_W + clog2(NUM_INPUTS+1) bits, with no truncation.
- Enabled cycle, neuron refractory (refr_cnt ≠ 0):
  - refr_cnt ← refr_cnt − 1
  - V held
  - inputs ignored
  - spike_out[n] ← 0
- Enabled cycle, neuron not refractory:
  - Leak: L = V − decay, floored at 0.
  - Integrate: S = L + I, saturated to 2^POT_W − 1.
  - If S ≥ threshold: spike_out[n] ← 1 and refr_cnt ← refractory_period. V ← 0 when reset_mode = 0; V ← S − threshold when reset_mode = 1.
  - Otherwise: V ← S and spike_out[n] ← 0.
- Disabled cycle (enable = 0): V and refr_cnt are held, and spike_out ← 0. A spike therefore lasts exactly one cycle.
- threshold = 0: the neuron fires on every non-refractory enabled cycle.
- refractory_period = 0: the neuron is eligible again on the next enabled cycle.
- Saturation is applied before the threshold compare.
- Config inputs (threshold, decay, refractory_period, reset_mode, weights) are sampled on each enabled cycle. Changing them mid-run takes effect on the next enabled cycle and never corrupts stored state.
- membrane_potential_out is a combinational mux of the registered V[dbg_sel]. It shows the stored potential and never the in-flight S. An out-of-range dbg_sel reads 0.

## Timing
- Reset assertion clears all V, refr_cnt and spike_out to 0 immediately and asynchronously, so membrane_potential_out = 0 during reset. Reset mid-refractory cancels the refractory period.
- After deassertion, the first rising edge with enable = 1 performs the first update.
- Latency: input_spikes sampled at edge k produce spike_out and the new V visible after edge k. That is one cycle, with no pipelining.
- Neurons update in parallel in the same cycle and have no cross-neuron dependency.

## Structure
- Package lif_pkg holds:
  - reset-mode constants LIF_RESET_ZERO = 1'b0 and LIF_RESET_SUB = 1'b1
  - a function for current width: WEIGHT_W + clog2(NUM_INPUTS+1)
- Sub-module lif_neuron_core is one neuron: current sum, leak, saturate, compare and refractory counter. It takes the common config plus its own weight row and is instantiated NUM_NEURONS times by generate.
- The top level contains only the generate loop and the debug mux.

## Test plan
Defaults unless stated; weights listed per neuron.
1. Reset/idle: hold reset = 0 while enable toggles → spike_out = 0, potential = 0. Release reset with enable = 0 for 5 cycles → no change.
2. Integrate-and-fire, zero mode:
   - Setup: neuron 0 all weights 3, threshold 20, decay 0, refractory 0, all spikes 1.
   - Cycle 1: I = 24 → spike_out[0] = 1, V = 0.
   - Subtract mode with the same setup → V = 4, then fires each cycle.
3. Leak and saturation:
   - Setup: weights 3, threshold 31, decay 2, inputs 0xFF.
   - Cycle 1: V = 24, no spike.
   - Cycle 2: max(22, 0) + 24 saturates to 31 → spike, V = 0.
   - With inputs 0 from V = 24 and decay 2 → 22, 20, …, reaching 0 and staying at 0.
4. Refractory: refractory 3, firing drive held → spikes on cycles 1, 5, 9. V is unchanged during cycles 2–4. Deasserting enable in cycle 3 for 2 cycles stretches the gap by exactly 2.
5. Multi-neuron and debug:
   - Setup: neuron n weights = n (0..3), all inputs 1, threshold 16.
   - Neuron 0 never fires. Neuron 3 (I = 24) fires on cycle 1. Neuron 2 (I = 16) fires on cycle 1. Neuron 1 (I = 8) fires on cycle 2.
   - Sweeping dbg_sel shows each neuron's stored V.
6. Async reset mid-run: assert reset between edges while V = 17 and refr_cnt = 2 → outputs go to 0 before the next edge. After release, the neuron fires without waiting out the refractory period.
